prog_sequencer: RTL
===================

# prog_sequencer

Run-control sequencer that sits between the host/testbench and the single-cycle core's `start`/`done` pins. It launches up to NUM_PROGS programs back-to-back, each from its own instruction-memory base address. For each program it holds `start` for a fixed window, then counts execution cycles until `done` or a timeout, and reports per-program results plus a final completion pulse.

## Interface
Parameters:
- NUM_PROGS, 3: number of program slots; slot index width PW = $clog2(NUM_PROGS), minimum 1.
- PC_W, 12: instruction address width, matches core PC.
- CYC_W, 16: cycle-counter width.
- START_CYC, 2: cycles `core_start` is held high per launch, ≥1.
- TIMEOUT_CYC, 50000: maximum RUN cycles per program, ≥1, < 2^CYC_W.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  one clock; reset is synchronous and active-high.
- run_req  in  1  host request to run the enabled program set; sampled only in IDLE.
- prog_mask  in  NUM_PROGS  enable bit per slot; latched when run_req is accepted.
- base_addr  in  NUM_PROGS*PC_W  flat base addresses; slot i at [i*PC_W +: PC_W].
- core_start  out  1  drives core `start`.
- core_base  out  PC_W  PC load value, valid while core_start=1.
- core_done  in  1  core `done` level.
- busy  out  1  high in every state except IDLE.
- cur_prog  out  PW  slot currently launched or running.
- result_valid  out  1  one-cycle pulse per finished program.
- result_prog  out  PW  slot of the latest result.
- cyc_count  out  CYC_W  RUN-cycle count of the latest result.
- timeout_err  out  1  sticky: some program in this run timed out.
- all_done  out  1  one-cycle pulse when the run completes.

## Operation
- States: IDLE, SELECT, START, RUN, RECORD, FINISH.
- IDLE: run_req=1 → pend ← prog_mask, timeout_err ← 0, go to SELECT. run_req in any other state is ignored.
- SELECT: if pend==0, go to FINISH. Otherwise cur_prog ← index of the lowest set bit of pend, clear that bit, start_cnt ← 0, go to START.
- START: core_start=1 and core_base = base[cur_prog] for exactly START_CYC cycles. Then go to RUN with run_cnt ← 0.
- RUN: core_done=1 → cyc_count ← run_cnt+1, go to RECORD. Else if run_cnt == TIMEOUT_CYC-1 → cyc_count ← TIMEOUT_CYC, timeout_err ← 1, go to RECORD. Else run_cnt ← run_cnt+1.
  - If core_done=1 on the timeout cycle, done wins: count = TIMEOUT_CYC, no error.
- core_done is ignored outside RUN, because a stale `done` level from the previous program must not end the next one.
- RECORD: result_valid=1, result_prog=cur_prog, go to SELECT.
- FINISH: all_done=1, go to IDLE.
- Mask = 0: run_req → SELECT → FINISH; all_done pulses, no result_valid.
- A timeout does not abort the run; the remaining slots still launch, since START reloads the PC.
- core_base = 0 when core_start=0.

## Timing
- Reset (any state, mid-run included): state=IDLE, pend=0. Outputs: core_start=0, core_base=0, busy=0, cur_prog=0, result_valid=0, result_prog=0, cyc_count=0, timeout_err=0, all_done=0.
- run_req high in cycle n (IDLE):
  - SELECT in n+1.
  - core_start high in n+2 … n+1+START_CYC.
  - First RUN cycle is n+2+START_CYC.
- core_done seen in RUN cycle k (k=1 is the first RUN cycle): cyc_count=k and result_valid are visible in the next cycle (RECORD).
- Per-program overhead outside RUN: SELECT + START_CYC + RECORD = START_CYC+2 cycles.
- all_done comes one cycle after the final SELECT. busy drops in the cycle after all_done.
- cyc_count, result_prog and timeout_err hold their values until they are next updated.

## Test plan
- Reset/idle: reset for 2 cycles → all outputs 0. Pulse run_req with prog_mask=0 → busy for 2 cycles (SELECT, FINISH), all_done once, no result_valid.
- Single program: mask=3'b010, base1=12'h040, START_CYC=2, core_done raised in the 5th RUN cycle → core_start high 2 cycles with core_base=12'h040; then result_valid with result_prog=1, cyc_count=5; then all_done.
- Ordering with stale done: mask=3'b101, bases 12'h000/12'h200, core_done left high after slot 0 finishes.
  - Slot 2 still gets 2 START cycles and ≥1 RUN cycle, giving cyc_count=1.
  - Results arrive for slot 0 then slot 2.
- Timeout: TIMEOUT_CYC=100, mask=3'b001, core_done held 0 → result cyc_count=100, timeout_err=1, then all_done. A new run_req clears timeout_err.
- Done on the boundary: core_done first high in RUN cycle 100 with TIMEOUT_CYC=100 → cyc_count=100, timeout_err=0.
- Reset mid-run: assert reset during slot 1 RUN → next cycle IDLE, all outputs 0. A later run_req with mask=3'b011 starts from slot 0.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches the enabled program slots in order, times each run and reports results.
// Each slot gets a fixed start window, then runs until done or a timeout.
module prog_sequencer #(
   parameter int NUM_PROGS   = 3,
   parameter int PC_W        = 12,
   parameter int CYC_W       = 16,
   parameter int START_CYC   = 2,
   parameter int TIMEOUT_CYC = 50000,
   localparam int PW = NUM_PROGS > 1 ? $clog2(NUM_PROGS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run_req,
   input  logic [NUM_PROGS-1:0]      prog_mask,
   input  logic [NUM_PROGS*PC_W-1:0] base_addr,
   output logic                      core_start,
   output logic [PC_W-1:0]           core_base,
   input  logic                      core_done,
   output logic                      busy,
   output logic [PW-1:0]             cur_prog,
   output logic                      result_valid,
   output logic [PW-1:0]             result_prog,
   output logic [CYC_W-1:0]          cyc_count,
   output logic                      timeout_err,
   output logic                      all_done
);
   localparam int SW = START_CYC > 1 ? $clog2(START_CYC) : 1;

   typedef enum logic [2:0] {IDLE, SELECT, START, RUN, RECORD, FINISH} state_t;

   state_t               state;
   logic [NUM_PROGS-1:0] pend;
   logic [SW-1:0]        start_cnt;
   logic [CYC_W-1:0]     run_cnt;
   logic [PW-1:0]        nxt;
   logic [PC_W-1:0]      nxt_base;

   always_comb begin
      nxt = '0;
      for (int i = NUM_PROGS - 1; i >= 0; i--)
         if (pend[i]) nxt = PW'(i);
      nxt_base = base_addr[nxt*PC_W +: PC_W];
   end

   // Outputs are registered on the transition into the state that shows them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pend         <= '0;
         start_cnt    <= '0;
         run_cnt      <= '0;
         core_start   <= 1'b0;
         core_base    <= '0;
         busy         <= 1'b0;
         cur_prog     <= '0;
         result_valid <= 1'b0;
         result_prog  <= '0;
         cyc_count    <= '0;
         timeout_err  <= 1'b0;
         all_done     <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         all_done     <= 1'b0;
         case (state)
            IDLE: if (run_req) begin
               pend        <= prog_mask;
               timeout_err <= 1'b0;
               busy        <= 1'b1;
               state       <= SELECT;
            end
            SELECT: if (pend == '0) begin
               all_done <= 1'b1;
               state    <= FINISH;
            end else begin
               cur_prog   <= nxt;
               pend       <= pend & (pend - 1'b1);
               start_cnt  <= '0;
               core_start <= 1'b1;
               core_base  <= nxt_base;
               state      <= START;
            end
            START: if (start_cnt == SW'(START_CYC - 1)) begin
               core_start <= 1'b0;
               core_base  <= '0;
               run_cnt    <= '0;
               state      <= RUN;
            end else begin
               start_cnt <= start_cnt + 1'b1;
            end
            // done takes priority over the timeout on the final cycle
            RUN: if (core_done || run_cnt == CYC_W'(TIMEOUT_CYC - 1)) begin
               cyc_count    <= run_cnt + 1'b1;
               timeout_err  <= timeout_err | ~core_done;
               result_valid <= 1'b1;
               result_prog  <= cur_prog;
               state        <= RECORD;
            end else begin
               run_cnt <= run_cnt + 1'b1;
            end
            RECORD: state <= SELECT;
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
